arc4_encrypt_prga: RTL and testbench
====================================

// Module: arc4_encrypt_prga
// PURPOSE
//  - ARC4 keystream encryptor. Reads a length-prefixed plaintext buffer from pt memory.
//  - Runs the PRGA over an S array that has already been initialised and key-scheduled.
//  - Writes the length-prefixed ciphertext to ct memory: ct[0]=L, ct[k]=pt[k]^ks[k] for k=1..L.
//  - Writer-side counterpart of the decryption PRGA. It sits in the same top level and shares
//    the S memory with init/KSA through a mux owned by the top level.
// PARAMETERS
//  ADDR_W  8  address width of the S, pt and ct memories (256-entry)
//  DATA_W  8  data width of the S, pt and ct memories
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous active-low reset
//  en         in   1       start request; sampled only while rdy=1
//  rdy        out  1       idle and able to accept en
//  s_addr     out  ADDR_W  S memory address
//  s_rddata   in   DATA_W  S read data (1-cycle synchronous read)
//  s_wrdata   out  DATA_W  S write data
//  s_wren     out  1       S write enable
//  pt_addr    out  ADDR_W  plaintext read address
//  pt_rddata  in   DATA_W  plaintext read data (1-cycle synchronous read)
//  ct_addr    out  ADDR_W  ciphertext write address
//  ct_wrdata  out  DATA_W  ciphertext write data
//  ct_wren    out  1       ciphertext write enable
// BEHAVIOUR
//  - Reset: state=IDLE, rdy=1, all *_wren=0, all addr/wrdata=0. i=1, j=0, k=1, length=0.
//  - Handshake: rdy is combinational (state==IDLE).
//    - en&rdy at edge E0 starts a job; rdy=0 from cycle E0+1.
//    - en while rdy=0 is ignored; no restart.
//    - rdy returns to 1 at cycle E0+3+6L.
//  - Memory timing: an address driven in state X yields rddata in state X+1.
//  - States and per-state actions:
//    IDLE:   outputs idle. On en: i<=1, j<=0, k<=1, go to RD_LEN.
//    RD_LEN: pt_addr=0.
//    WR_LEN: ct_addr=0, ct_wrdata=pt_rddata, ct_wren=1, length<=pt_rddata.
//            Go to IDLE if pt_rddata==0, else RD_SI.
//    RD_SI:  s_addr=i.
//    RD_SJ:  si<=s_rddata, j<=j+s_rddata (mod 256), s_addr=j+s_rddata.
//    WR_SI:  s_addr=i, s_wrdata=s_rddata, s_wren=1, sj<=s_rddata.
//    WR_SJ:  s_addr=j, s_wrdata=si, s_wren=1.
//    RD_KS:  s_addr=si+sj (mod 256), pt_addr=k.
//    XOR_WR: ct_addr=k, ct_wrdata=s_rddata^pt_rddata, ct_wren=1.
//            If k==length, go to IDLE; else i<=i+1, k<=k+1, go to RD_SI.
//  - Every state other than IDLE lasts exactly 1 cycle; 6 cycles per byte.
//  - Arithmetic: all index sums are 8-bit and wrap modulo 256.
//    - Termination uses the equality k==length, tested before increment, so L=255 never wraps k.
//  - Boundaries:
//    - L=0: exactly one ct write (ct[0]=0); no S writes.
//    - i==j: both swap writes occur; S is unchanged.
//    - At most one of s_wren/ct_wren is high in any cycle.
//  - Reset mid-operation: return to IDLE on the next edge; all wren are 0 from then on.
//    Memory contents already written are not restored.
//  - Outputs are undefined only for illegal state encodings; the default branch forces IDLE.
// STRUCTURE
//  - arc4_pkg (shared): ADDR_W/DATA_W constants and the state enum type.
//    The PRGA state list is shared with the decryptor.
//  - Optional sub-module arc4_ks_step: the RD_SI..RD_KS swap/keystream sequencer,
//    reusable by the decryptor. Otherwise a single flat FSM.
// TESTING
//  1. S=identity, pt={2,0x41,0x42}, en pulse
//     -> ct={0x02,0x43,0x47}; S[2]=3, S[3]=2; rdy high at E0+15.
//  2. pt[0]=0, en -> single ct write ct[0]=0; s_wren never 1; rdy high at E0+3.
//  3. en held high during a job (S=identity, L=2)
//     -> no restart; outputs identical to test 1; next job starts only after rdy=1.
//  4. rst_n=0 at E0+10 during a job -> all wren=0 from E0+11; rdy=1; next en runs a clean job.
//  5. L=255 with random pt and S from KSA(key=0x000123)
//     -> exactly 256 ct writes; rdy at E0+1533; running the decryptor on ct recovers pt.
//  6. Assertions: one-hot write enables; no s_wren outside WR_SI/WR_SJ;
//     pt/ct addresses stay within 0..L.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: memory geometry and the PRGA state list used by the
// encrypt and decrypt keystream engines.
package arc4_pkg;

  localparam int ARC4_ADDR_W = 8;
  localparam int ARC4_DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_WR_LEN,
    ST_RD_SI,
    ST_RD_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_KS,
    ST_XOR_WR
  } prga_state_t;

endpackage

// File: rtl/arc4_encrypt_prga.sv
// ARC4 keystream encryptor: reads a length-prefixed plaintext, runs the PRGA over a
// key-scheduled S array and writes the length-prefixed ciphertext.
module arc4_encrypt_prga
  import arc4_pkg::*;
#(
  parameter int ADDR_W = ARC4_ADDR_W,
  parameter int DATA_W = ARC4_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_rddata,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] pt_addr,
  input  logic [DATA_W-1:0] pt_rddata,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [DATA_W-1:0] ct_wrdata,
  output logic              ct_wren
);

  prga_state_t       state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] length;
  logic [DATA_W-1:0] si;
  logic [DATA_W-1:0] sj;

  assign rdy = (state == ST_IDLE);

  // Each non-idle state lasts one cycle; memory read data arrives in the state after
  // the one that drove the address, so the sequence is fixed at six cycles per byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      i      <= ADDR_W'(1);
      j      <= '0;
      k      <= ADDR_W'(1);
      length <= '0;
      si     <= '0;
      sj     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            i     <= ADDR_W'(1);
            j     <= '0;
            k     <= ADDR_W'(1);
            state <= ST_RD_LEN;
          end
        end
        ST_RD_LEN: state <= ST_WR_LEN;
        ST_WR_LEN: begin
          length <= pt_rddata;
          state  <= (pt_rddata == '0) ? ST_IDLE : ST_RD_SI;
        end
        ST_RD_SI: state <= ST_RD_SJ;
        ST_RD_SJ: begin
          si    <= s_rddata;
          j     <= j + s_rddata;
          state <= ST_WR_SI;
        end
        ST_WR_SI: begin
          sj    <= s_rddata;
          state <= ST_WR_SJ;
        end
        ST_WR_SJ: state <= ST_RD_KS;
        ST_RD_KS: state <= ST_XOR_WR;
        ST_XOR_WR: begin
          // Compare before incrementing so a 255-byte message never wraps k.
          if (k == length) begin
            state <= ST_IDLE;
          end else begin
            i     <= i + ADDR_W'(1);
            k     <= k + ADDR_W'(1);
            state <= ST_RD_SI;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The j address in RD_SJ depends on the S data returned that same cycle, so memory
  // controls are decoded from the current state rather than registered ahead.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    case (state)
      ST_RD_LEN: pt_addr = '0;
      ST_WR_LEN: begin
        ct_addr   = '0;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      ST_RD_SI: s_addr = i;
      ST_RD_SJ: s_addr = j + s_rddata;
      ST_WR_SI: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      ST_WR_SJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      ST_RD_KS: begin
        s_addr  = si + sj;
        pt_addr = k;
      end
      ST_XOR_WR: begin
        ct_addr   = k;
        ct_wrdata = s_rddata ^ pt_rddata;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt_prga.sv
// Scoreboard bench for arc4_encrypt_prga: behavioural S/pt/ct memories, expected ct
// writes queued at stimulus time and popped by an independent monitor.
module tb_arc4_encrypt_prga;
  import arc4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;

  logic [7:0] s_mem [256];
  logic [7:0] pt_mem[256];
  logic [7:0] ct_mem[256];
  logic [7:0] s_init[256];
  logic [7:0] ks_arr[256];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } ct_exp_t;

  ct_exp_t exp_q[$];
  ct_exp_t mon_e;
  int      errors = 0;
  int      checks = 0;
  int      ct_writes = 0;
  int      s_writes = 0;
  int      cur_len = 0;
  int      cyc;

  arc4_encrypt_prga dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expected ct write per observed write and watches write hygiene.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_wren) s_writes++;
      if (s_wren && ct_wren) checkOutput("wren_onehot", {s_wren, ct_wren}, 32'h1);
      if (pt_addr > cur_len) checkOutput("pt_addr_range", pt_addr, cur_len);
      if (ct_wren) begin
        ct_writes++;
        if (ct_addr > cur_len) checkOutput("ct_addr_range", ct_addr, cur_len);
        if (exp_q.size() == 0) begin
          checkOutput("ct_unexpected_write", {ct_addr, ct_wrdata}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("ct_addr", ct_addr, mon_e.addr);
          checkOutput("ct_data", ct_wrdata, mon_e.data);
        end
      end
    end
  end

  task automatic pushExp(input logic [7:0] a, input logic [7:0] d);
    ct_exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic loadIdentity();
    for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
  endtask

  task automatic loadTest1();
    loadIdentity();
    pt_mem[0] = 8'd2;
    pt_mem[1] = 8'h41;
    pt_mem[2] = 8'h42;
    cur_len = 2;
    pushExp(8'd0, 8'h02);
    pushExp(8'd1, 8'h43);
    pushExp(8'd2, 8'h47);
  endtask

  // Pulses (or holds) en and returns the cycle offset from E0 at which rdy is seen.
  task automatic applyStimulus(input bit hold, output int cycles);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    if (!hold) en = 1'b0;
    cycles = 1;
    while (!rdy && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    en = 1'b0;
    if (!rdy) checkOutput("rdy_timeout", cycles, 0);
  endtask

  task automatic genKeystream(input int len);
    logic [7:0] ms[256];
    logic [7:0] ii, jj, t;
    for (int n = 0; n < 256; n++) ms[n] = s_init[n];
    ii = 0;
    jj = 0;
    for (int n = 1; n <= len; n++) begin
      ii = ii + 8'd1;
      jj = jj + ms[ii];
      t = ms[ii];
      ms[ii] = ms[jj];
      ms[jj] = t;
      t = ms[ii] + ms[jj];
      ks_arr[n] = ms[t];
    end
  endtask

  initial begin
    logic [7:0] key[3];
    logic [7:0] jj, t;
    int bad;

    loadIdentity();
    for (int n = 0; n < 256; n++) begin
      pt_mem[n] = 8'h0;
      ct_mem[n] = 8'h0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_rdy", rdy, 1);
    checkOutput("reset_wren", {s_wren, ct_wren}, 0);
    checkOutput("reset_addr", {s_addr, pt_addr, ct_addr}, 0);
    checkOutput("reset_wrdata", {s_wrdata, ct_wrdata}, 0);
    rst_n = 1'b1;

    $display("[TB] test 1: L=2 identity S");
    loadTest1();
    applyStimulus(1'b0, cyc);
    checkOutput("t1_rdy_cycle", cyc, 15);
    checkOutput("t1_queue_drained", exp_q.size(), 0);
    checkOutput("t1_s2", s_mem[2], 3);
    checkOutput("t1_s3", s_mem[3], 2);

    $display("[TB] test 2: L=0");
    pt_mem[0] = 8'd0;
    cur_len = 0;
    s_writes = 0;
    ct_writes = 0;
    pushExp(8'd0, 8'd0);
    applyStimulus(1'b0, cyc);
    checkOutput("t2_rdy_cycle", cyc, 3);
    checkOutput("t2_ct_writes", ct_writes, 1);
    checkOutput("t2_s_writes", s_writes, 0);

    $display("[TB] test 3: en held high");
    ct_writes = 0;
    loadTest1();
    applyStimulus(1'b1, cyc);
    checkOutput("t3_rdy_cycle", cyc, 15);
    repeat (2) @(negedge clk);
    checkOutput("t3_no_restart", rdy, 1);
    checkOutput("t3_ct_writes", ct_writes, 3);
    checkOutput("t3_queue_drained", exp_q.size(), 0);

    $display("[TB] test 4: reset mid-job");
    ct_writes = 0;
    loadIdentity();
    pushExp(8'd0, 8'h02);
    pushExp(8'd1, 8'h43);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t4_rdy_after_reset", rdy, 1);
    checkOutput("t4_wren_after_reset", {s_wren, ct_wren}, 0);
    @(negedge clk);
    checkOutput("t4_wren_held_low", {s_wren, ct_wren}, 0);
    rst_n = 1'b1;
    checkOutput("t4_partial_writes", ct_writes, 2);
    checkOutput("t4_queue_drained", exp_q.size(), 0);
    loadTest1();
    applyStimulus(1'b0, cyc);
    checkOutput("t4_clean_rdy_cycle", cyc, 15);
    checkOutput("t4_clean_queue_drained", exp_q.size(), 0);

    $display("[TB] test 5: L=255, KSA key 0x000123");
    key[0] = 8'h00;
    key[1] = 8'h01;
    key[2] = 8'h23;
    loadIdentity();
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s_mem[n] + key[n % 3];
      t = s_mem[n];
      s_mem[n] = s_mem[jj];
      s_mem[jj] = t;
    end
    for (int n = 0; n < 256; n++) s_init[n] = s_mem[n];
    pt_mem[0] = 8'd255;
    for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
    cur_len = 255;
    ct_writes = 0;
    genKeystream(255);
    pushExp(8'd0, 8'd255);
    for (int n = 1; n <= 255; n++) pushExp(8'(n), pt_mem[n] ^ ks_arr[n]);
    applyStimulus(1'b0, cyc);
    checkOutput("t5_rdy_cycle", cyc, 1533);
    checkOutput("t5_ct_writes", ct_writes, 256);
    checkOutput("t5_queue_drained", exp_q.size(), 0);
    checkOutput("t5_ct0", ct_mem[0], 255);
    genKeystream(255);
    bad = 0;
    for (int n = 1; n <= 255; n++) if ((ct_mem[n] ^ ks_arr[n]) !== pt_mem[n]) bad++;
    checkOutput("t5_decrypt_mismatches", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
